// File: rtl/clk_rst_sequencer_if.sv
// Signal bundle between clk_rst_sequencer and its environment.
//
// Every signal here is level-sampled on clk_i. There is no valid/ready
// handshake. sw_rst_i and clr_i are single-cycle request pulses that act in
// the cycle they are high. pll_lock_i is asynchronous and is resynchronised
// inside the sequencer. All outputs change only after a clock edge (or on
// reset).
//
//   master : environment side. Drives pll_lock_i, sw_rst_i, clr_i and div_i.
//   slave  : sequencer side. Drives sys_rstn_o, ce_o, state_o and lock_lost_o.
interface clk_rst_sequencer_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16
);
  logic                          pll_lock_i;
  logic                          sw_rst_i;
  logic                          clr_i;
  logic [NUM_CH*DIV_WIDTH-1:0]   div_i;
  logic                          sys_rstn_o;
  logic [NUM_CH-1:0]             ce_o;
  logic [1:0]                    state_o;
  logic                          lock_lost_o;

  modport master (
    output pll_lock_i, sw_rst_i, clr_i, div_i,
    input  sys_rstn_o, ce_o, state_o, lock_lost_o
  );

  modport slave (
    input  pll_lock_i, sw_rst_i, clr_i, div_i,
    output sys_rstn_o, ce_o, state_o, lock_lost_o
  );
endinterface

// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer placed between the PLL lock output and the SoC.
// Qualifies PLL lock, then holds the system in reset for RST_HOLD cycles
// before releasing it. Flags a lock loss that happens in RUN, and generates
// NUM_CH programmable clock-enable strobes while the system runs.
//
// Ports:
//   clk_i            system clock (PLL output)
//   rst_i            asynchronous active-high reset
//   bus (slave)      pll_lock_i   : PLL lock, asynchronous to clk_i
//                    sw_rst_i     : software reset request pulse
//                    clr_i        : clears lock_lost_o
//                    div_i        : per-channel divider D, channel k uses [k*DIV_WIDTH +: DIV_WIDTH]
//                    sys_rstn_o   : active-low system reset, high only in RUN
//                    ce_o         : per-channel one-cycle clock-enable strobes
//                    state_o      : 0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RUN
//                    lock_lost_o  : sticky flag, lock dropped while in RUN
module clk_rst_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD    = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  clk_rst_sequencer_if.slave  bus
);

  localparam int CNT_MAX = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0]     FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_FILTER    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   run_q, run_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lock_s;

  logic [DIV_WIDTH-1:0]   ch_cnt_q [NUM_CH];
  logic [DIV_WIDTH-1:0]   ch_cnt_d [NUM_CH];
  logic [DIV_WIDTH-1:0]   dl_q     [NUM_CH];
  logic [DIV_WIDTH-1:0]   dl_d     [NUM_CH];
  logic [NUM_CH-1:0]      ce_vec;

  // Only the first synchroniser stage ever looks at pll_lock_i.
  assign lock_s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_lock_i};

  // Sequencer next state. The shared counter is cleared on every state change,
  // so each state counts from 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q & ~bus.clr_i;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_FILTER;
      end
      ST_FILTER: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (bus.sw_rst_i) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        // Lock loss outranks a software reset, and a new loss outranks clr_i.
        if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          lock_lost_d = 1'b1;
        end else if (bus.sw_rst_i) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    run_d = (state_d == ST_RUN);
  end

  // Strobes depend only on flops, so ce_o falls in the same cycle as
  // sys_rstn_o when RUN is left.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ce_vec[k] = run_q && (ch_cnt_q[k] == dl_q[k]);
    end
  end

  // The divider is only re-latched at a wrap while running, so a div_i change
  // never cuts short or doubles a period.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_cnt_d[k] = ch_cnt_q[k];
      dl_d[k]     = dl_q[k];
      if (!run_q || !run_d) begin
        ch_cnt_d[k] = '0;
        dl_d[k]     = bus.div_i[k*DIV_WIDTH +: DIV_WIDTH];
      end else if (ce_vec[k]) begin
        ch_cnt_d[k] = '0;
        dl_d[k]     = bus.div_i[k*DIV_WIDTH +: DIV_WIDTH];
      end else begin
        ch_cnt_d[k] = ch_cnt_q[k] + DIV_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      sync_q      <= '0;
      run_q       <= 1'b0;
      lock_lost_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_cnt_q[k] <= '0;
        dl_q[k]     <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      run_q       <= run_d;
      lock_lost_q <= lock_lost_d;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_cnt_q[k] <= ch_cnt_d[k];
        dl_q[k]     <= dl_d[k];
      end
    end
  end

  // run_q is a dedicated flop, so sys_rstn_o has no decode glitches.
  assign bus.sys_rstn_o  = run_q;
  assign bus.ce_o        = ce_vec;
  assign bus.state_o     = state_q;
  assign bus.lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
module tb_clk_rst_sequencer;
  localparam int NUM_CH = 4;
  localparam int DW     = 16;

  // Hand-derived timing for default parameters (SYNC_STAGES=2, LOCK_FILTER=16,
  // RST_HOLD=1024), counted in edges from the first high lock sample.
  localparam int EXP_FILTER_EDGE = 3;
  localparam int EXP_HOLD_EDGE   = 19;
  localparam int EXP_RUN_EDGE    = 1043;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  clk_rst_sequencer_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) bus ();

  clk_rst_sequencer #(
    .NUM_CH(NUM_CH), .DIV_WIDTH(DW), .SYNC_STAGES(2),
    .LOCK_FILTER(16), .RST_HOLD(1024)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.pll_lock_i = 1'b0;
    bus.sw_rst_i   = 1'b0;
    bus.clr_i      = 1'b0;
    bus.div_i      = {16'd0, 16'd1, 16'd4, 16'd65535};
    repeat (3) tick();
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
    checks++; if (bus.sys_rstn_o !== 1'b0) begin failures++; $display("FAIL reset_rstn got=%0b exp=0", bus.sys_rstn_o); end
    checks++; if (bus.ce_o !== 4'h0) begin failures++; $display("FAIL reset_ce got=%h exp=0", bus.ce_o); end
    checks++; if (bus.lock_lost_o !== 1'b0) begin failures++; $display("FAIL reset_lost got=%0b exp=0", bus.lock_lost_o); end
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL idle_nolock_state got=%0d exp=0", bus.state_o); end
  endtask

  task automatic test_lock_qualification;
    int first_filter = -1;
    int first_hold   = -1;
    int first_run    = -1;
    int early_ce     = 0;
    bus.pll_lock_i = 1'b1;
    for (int n = 1; n <= 1100 && first_run < 0; n++) begin
      tick();
      if (bus.state_o == 2'd1 && first_filter < 0) first_filter = n;
      if (bus.state_o == 2'd2 && first_hold < 0) first_hold = n;
      if (bus.sys_rstn_o == 1'b1) first_run = n;
      if (bus.sys_rstn_o == 1'b0 && bus.ce_o != 4'h0) early_ce++;
    end
    checks++; if (first_filter !== EXP_FILTER_EDGE) begin failures++; $display("FAIL qual_filter_edge got=%0d exp=%0d", first_filter, EXP_FILTER_EDGE); end
    checks++; if (first_hold !== EXP_HOLD_EDGE) begin failures++; $display("FAIL qual_hold_edge got=%0d exp=%0d", first_hold, EXP_HOLD_EDGE); end
    checks++; if (first_run !== EXP_RUN_EDGE) begin failures++; $display("FAIL qual_run_edge got=%0d exp=%0d", first_run, EXP_RUN_EDGE); end
    checks++; if (early_ce !== 0) begin failures++; $display("FAIL qual_ce_before_run got=%0d exp=0", early_ce); end
    checks++; if (bus.state_o !== 2'd3) begin failures++; $display("FAIL qual_run_state got=%0d exp=3", bus.state_o); end
    checks++; if (bus.ce_o !== 4'b1000) begin failures++; $display("FAIL qual_first_run_ce got=%b exp=1000", bus.ce_o); end
  endtask

  task automatic test_sw_reset;
    int low = 0;
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    checks++; if (bus.state_o !== 2'd2) begin failures++; $display("FAIL swrst_state got=%0d exp=2", bus.state_o); end
    checks++; if (bus.sys_rstn_o !== 1'b0) begin failures++; $display("FAIL swrst_rstn got=%0b exp=0", bus.sys_rstn_o); end
    low = 1;
    for (int i = 0; i < 3000 && bus.sys_rstn_o == 1'b0; i++) begin
      tick();
      if (bus.sys_rstn_o == 1'b0) low++;
    end
    checks++; if (low !== 1024) begin failures++; $display("FAIL swrst_low_cycles got=%0d exp=1024", low); end
    checks++; if (bus.state_o !== 2'd3) begin failures++; $display("FAIL swrst_back_run got=%0d exp=3", bus.state_o); end

    // Second request at hold cycle 500 restarts the hold count.
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    low = 1;
    repeat (499) begin
      tick();
      if (bus.sys_rstn_o == 1'b0) low++;
    end
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    if (bus.sys_rstn_o == 1'b0) low++;
    checks++; if (bus.state_o !== 2'd2) begin failures++; $display("FAIL swrst_restart_state got=%0d exp=2", bus.state_o); end
    for (int i = 0; i < 3000 && bus.sys_rstn_o == 1'b0; i++) begin
      tick();
      if (bus.sys_rstn_o == 1'b0) low++;
    end
    checks++; if (low !== 1524) begin failures++; $display("FAIL swrst_restart_low_cycles got=%0d exp=1524", low); end
  endtask

  task automatic test_dividers;
    int d_val [NUM_CH]     = '{65535, 4, 1, 0};
    int exp_first [NUM_CH] = '{65536, 5, 2, 1};
    int first [NUM_CH]     = '{-1, -1, -1, -1};
    int mism [NUM_CH]      = '{0, 0, 0, 0};
    logic exp_ce;
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    for (int i = 0; i < 2000 && bus.sys_rstn_o == 1'b0; i++) tick();
    checks++; if (bus.sys_rstn_o !== 1'b1) begin failures++; $display("FAIL div_wait_run got=%0b exp=1", bus.sys_rstn_o); end
    for (int r = 1; r <= 65537; r++) begin
      if (r > 1) tick();
      for (int k = 0; k < NUM_CH; k++) begin
        exp_ce = ((r % (d_val[k] + 1)) == 0);
        if (bus.ce_o[k] !== exp_ce) mism[k]++;
        if (bus.ce_o[k] === 1'b1 && first[k] < 0) first[k] = r;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++; if (first[k] !== exp_first[k]) begin failures++; $display("FAIL div_first_ch%0d got=%0d exp=%0d", k, first[k], exp_first[k]); end
      checks++; if (mism[k] !== 0) begin failures++; $display("FAIL div_period_ch%0d bad_cycles got=%0d exp=0", k, mism[k]); end
    end
  endtask

  task automatic test_div_change;
    int mism    = 0;
    int strobes = 0;
    logic exp_ce;
    for (int i = 0; i < 10 && bus.ce_o[1] !== 1'b1; i++) tick();
    checks++; if (bus.ce_o[1] !== 1'b1) begin failures++; $display("FAIL divchg_align got=%0b exp=1", bus.ce_o[1]); end
    repeat (2) tick();
    bus.div_i[31:16] = 16'd2;
    for (int s = 3; s <= 15; s++) begin
      tick();
      exp_ce = (s == 5) || (s == 8) || (s == 11) || (s == 14);
      if (bus.ce_o[1] !== exp_ce) mism++;
      if (bus.ce_o[1] === 1'b1) strobes++;
    end
    checks++; if (mism !== 0) begin failures++; $display("FAIL divchg_pattern bad_cycles got=%0d exp=0", mism); end
    checks++; if (strobes !== 4) begin failures++; $display("FAIL divchg_strobes got=%0d exp=4", strobes); end
  endtask

  task automatic test_lock_loss;
    bus.pll_lock_i = 1'b0;
    tick();
    tick();
    checks++; if (bus.sys_rstn_o !== 1'b1) begin failures++; $display("FAIL loss_rstn_early got=%0b exp=1", bus.sys_rstn_o); end
    checks++; if (bus.ce_o[3] !== 1'b1) begin failures++; $display("FAIL loss_ce_early got=%0b exp=1", bus.ce_o[3]); end
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    checks++; if (bus.sys_rstn_o !== 1'b0) begin failures++; $display("FAIL loss_rstn got=%0b exp=0", bus.sys_rstn_o); end
    checks++; if (bus.ce_o !== 4'h0) begin failures++; $display("FAIL loss_ce got=%h exp=0", bus.ce_o); end
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL loss_state got=%0d exp=0", bus.state_o); end
    checks++; if (bus.lock_lost_o !== 1'b1) begin failures++; $display("FAIL loss_set_over_clr got=%0b exp=1", bus.lock_lost_o); end
    tick();
    checks++; if (bus.lock_lost_o !== 1'b1) begin failures++; $display("FAIL loss_sticky got=%0b exp=1", bus.lock_lost_o); end
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    checks++; if (bus.lock_lost_o !== 1'b0) begin failures++; $display("FAIL loss_clear got=%0b exp=0", bus.lock_lost_o); end
  endtask

  task automatic test_lock_glitch;
    int   first_run  = -1;
    int   state_at2  = -1;
    logic rstn_seen  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.pll_lock_i = 1'b1;
    repeat (10) begin
      tick();
      if (bus.sys_rstn_o == 1'b1) rstn_seen = 1'b1;
    end
    bus.pll_lock_i = 1'b0;
    tick();
    if (bus.sys_rstn_o == 1'b1) rstn_seen = 1'b1;
    bus.pll_lock_i = 1'b1;
    bus.sw_rst_i   = 1'b1;  // must be ignored in WAIT_LOCK/FILTER
    for (int n = 1; n <= 1100 && first_run < 0; n++) begin
      tick();
      if (n == 2) state_at2 = int'(bus.state_o);
      if (n == 10) bus.sw_rst_i = 1'b0;
      if (bus.sys_rstn_o == 1'b1) first_run = n;
    end
    bus.sw_rst_i = 1'b0;
    checks++; if (rstn_seen !== 1'b0) begin failures++; $display("FAIL glitch_rstn_pulse got=%0b exp=0", rstn_seen); end
    checks++; if (state_at2 !== 0) begin failures++; $display("FAIL glitch_back_to_wait got=%0d exp=0", state_at2); end
    checks++; if (first_run !== EXP_RUN_EDGE) begin failures++; $display("FAIL glitch_run_edge got=%0d exp=%0d", first_run, EXP_RUN_EDGE); end
  endtask

  task automatic test_reset_midop;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", bus.state_o); end
    checks++; if (bus.sys_rstn_o !== 1'b0) begin failures++; $display("FAIL midrst_rstn got=%0b exp=0", bus.sys_rstn_o); end
    checks++; if (bus.ce_o !== 4'h0) begin failures++; $display("FAIL midrst_ce got=%h exp=0", bus.ce_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    // Synchroniser was cleared, so lock is not yet visible two edges later.
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL midrst_sync_cleared got=%0d exp=0", bus.state_o); end
  endtask

  initial begin
    test_reset();
    test_lock_qualification();
    test_sw_reset();
    test_dividers();
    test_div_change();
    test_lock_loss();
    test_lock_glitch();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
- Parametrised clock-management successor to the bare iCE40 oscillator/PLL primitives.
- Sits between PLL lock output and the SoC. Qualifies PLL lock and sequences a synchronous system reset release.
- Detects loss of lock.
- Generates NUM_CH independently programmable clock-enable strobes, so peripherals run at derived rates without extra clock domains.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..8)
- DIV_WIDTH, 16, width of each channel divider value
- SYNC_STAGES, 2, synchroniser depth for pll_lock_i (>=2)
- LOCK_FILTER, 16, consecutive synchronised-lock cycles required before reset hold (>=1)
- RST_HOLD, 1024, cycles sys_rstn_o stays low after lock qualified (>=1)

Ports:
- clk_i, in, 1, system clock (PLL output)
- rst_i, in, 1, asynchronous active-high reset
- pll_lock_i, in, 1, PLL LOCK, asynchronous to clk_i
- sw_rst_i, in, 1, software reset request, synchronous pulse
- clr_i, in, 1, clears lock_lost_o
- div_i, in, NUM_CH*DIV_WIDTH, per-channel divider D; channel k uses bits [k*DIV_WIDTH +: DIV_WIDTH]
- sys_rstn_o, out, 1, active-low system reset; high only in RUN
- ce_o, out, NUM_CH, per-channel one-cycle clock-enable strobes
- state_o, out, 2, current state: 0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RUN
- lock_lost_o, out, 1, sticky flag: lock dropped while in RUN

Behaviour:
- Reset values (rst_i high): state WAIT_LOCK, all counters 0, synchroniser flops 0, sys_rstn_o=0, ce_o=0, lock_lost_o=0, state_o=0. Reset mid-operation returns to these values immediately.
- lock_s is pll_lock_i after SYNC_STAGES flops. No other logic samples pll_lock_i.
- WAIT_LOCK: counter held at 0. lock_s=1 -> FILTER.
- FILTER: counts cycles.
  - lock_s=0 -> WAIT_LOCK, counter cleared.
  - After LOCK_FILTER cycles in FILTER -> HOLD, counter cleared.
- HOLD: counts cycles.
  - lock_s=0 -> WAIT_LOCK.
  - sw_rst_i=1 restarts the hold count at 0.
  - After RST_HOLD cycles -> RUN.
- RUN: lock_s=0 has priority over sw_rst_i.
  - lock_s=0 -> WAIT_LOCK and sets lock_lost_o.
  - Else sw_rst_i=1 -> HOLD.
- sw_rst_i is ignored in WAIT_LOCK and FILTER.
- Latency: pll_lock_i first sampled high at edge 1 -> sys_rstn_o high after edge SYNC_STAGES+1+LOCK_FILTER+RST_HOLD. Defaults give 1043.
- sys_rstn_o is decoded directly from a dedicated RUN state flop. It is glitch-free, with no combinational path from inputs. Falls the cycle after the leaving transition edge registers.
- Counter width: clog2(max(LOCK_FILTER,RST_HOLD))+1. No wrap inside a state.
- lock_lost_o: set wins over clr_i in the same cycle. Holds until clr_i or rst_i.
- Clock enables, per channel k:
  - Counter cnt_k and latched divider dl_k.
  - Outside RUN: cnt_k=0, ce_o[k]=0, dl_k continuously loaded from div_i.
  - In RUN: ce_o[k] = (cnt_k==dl_k), combinational from flops only.
  - When cnt_k==dl_k: cnt_k wraps to 0 and dl_k reloads from div_i. Otherwise cnt_k increments.
  - Period is D+1 cycles. D=0 gives ce_o[k]=1 every RUN cycle.
  - First strobe falls in the (D+1)-th RUN cycle.
  - A div_i change takes effect only at the next wrap. No truncated or doubled pulses.
- Channels are fully independent. All strobes drop to 0 in the same cycle sys_rstn_o drops.

Test Plan:
- Lock qualification: defaults, rst_i pulse, pll_lock_i=1 steady -> sys_rstn_o rises exactly 1043 edges after the first high sample; state_o goes 0->1->2->3.
- Lock glitch in FILTER: pll_lock_i high 10 cycles, low 1 cycle, high again -> state returns to 0; full 1043-cycle count restarts from the second rise; sys_rstn_o never pulses high.
- Lock loss in RUN: drop pll_lock_i -> after 2 sync cycles plus 1 edge, sys_rstn_o=0, ce_o=0, lock_lost_o=1. clr_i in the same cycle as set -> stays 1; later clr_i -> 0.
- Software reset in RUN: sw_rst_i one cycle -> state_o=2, sys_rstn_o low for exactly 1024 cycles. Second sw_rst_i at hold cycle 500 -> low for 500+1024 total.
- Dividers: div_i = {D3=0, D2=1, D1=4, D0=65535} -> periods 1, 2, 5 and 65536 cycles; first strobes at RUN cycles 1, 2, 5 and 65536.
- Divider change: switch D1 from 4 to 2 mid-period -> current 5-cycle period completes, then 3-cycle periods; no extra or missing strobe.
